// File: rtl/keychain_pkg.sv
// -----------------------------------------------------------------------------
// keychain_pkg
// Shared types and constants for the keychain RSA datapath blocks.
//   mod_inverse_state_t : sequencing states of the modular-inverse engine
//   div_latency()       : cycles from divider start pulse to done pulse
// -----------------------------------------------------------------------------
package keychain_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    REDUCE,
    DIVIDE,
    UPDATE,
    FIXUP,
    DONE
  } mod_inverse_state_t;

  // One load cycle plus one shift-subtract step per quotient bit.
  function automatic int div_latency(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/divmod_seq.sv
// -----------------------------------------------------------------------------
// divmod_seq
// Restoring shift-subtract divider. A start pulse captures the operands; the
// done pulse arrives div_latency(WIDTH) cycles later and quotient/remainder
// then hold until the next start.
// Ports:
//   clk_in        system clock
//   rst_in        synchronous reset, active-high
//   start_in      one-cycle start request (operands sampled with it)
//   dividend_in   unsigned dividend
//   divisor_in    unsigned divisor (must be non-zero for a meaningful result)
//   quotient_out  dividend / divisor
//   remainder_out dividend % divisor
//   done_out      one-cycle pulse when quotient/remainder are final
// -----------------------------------------------------------------------------
module divmod_seq
  import keychain_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic [WIDTH-1:0] quotient_out,
  output logic [WIDTH-1:0] remainder_out,
  output logic             done_out
);

  localparam int LAT   = div_latency(WIDTH);
  localparam int CNT_W = $clog2(LAT + 1);

  logic             busy;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] divisor_reg;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;

  // Partial remainder shifted left with the next dividend bit; a set top bit
  // in the trial difference means the subtraction borrowed (restore).
  assign rem_shift = {remainder_out, quotient_out[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, divisor_reg};

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy          <= 1'b0;
      done_out      <= 1'b0;
      cnt           <= '0;
      quotient_out  <= '0;
      remainder_out <= '0;
    end else begin
      done_out <= 1'b0;
      if (start_in) begin
        quotient_out  <= dividend_in;
        remainder_out <= '0;
        divisor_reg   <= divisor_in;
        cnt           <= '0;
        busy          <= 1'b1;
      end else if (busy) begin
        if (!rem_diff[WIDTH]) begin
          remainder_out <= rem_diff[WIDTH-1:0];
          quotient_out  <= {quotient_out[WIDTH-2:0], 1'b1};
        end else begin
          remainder_out <= rem_shift[WIDTH-1:0];
          quotient_out  <= {quotient_out[WIDTH-2:0], 1'b0};
        end
        cnt <= cnt + CNT_W'(1);
        if (cnt == CNT_W'(LAT - 2)) begin
          busy     <= 1'b0;
          done_out <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mod_inverse.sv
// -----------------------------------------------------------------------------
// mod_inverse
// Computes x = a^-1 mod m with the iterative extended Euclidean algorithm
// (remainder sequence r0/r1, Bezout coefficient sequence t0/t1).
// Ports:
//   clk_in      system clock
//   rst_in      synchronous reset, active-high
//   ready_in    start request, sampled only in IDLE
//   value_in    a, captured on accepted start
//   modulus_in  m, captured on accepted start
//   value_out   inverse in [1,m-1], 0 on error; held until next completion
//   error_out   1 = no inverse (gcd(a,m) != 1 or m < 2)
//   busy_out    high from the cycle after accepted start until result registered
//   valid_out   one-cycle completion pulse
//   iter_out    Euclid iteration count of last job (MOD_INVERSE_ITER_EN only)
// Build option: define MOD_INVERSE_ITER_EN to add iter_out and its counter.
// -----------------------------------------------------------------------------
module mod_inverse
  import keychain_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             ready_in,
  input  logic [WIDTH-1:0] value_in,
  input  logic [WIDTH-1:0] modulus_in,
  output logic [WIDTH-1:0] value_out,
  output logic             error_out,
  output logic             busy_out,
  output logic             valid_out
`ifdef MOD_INVERSE_ITER_EN
  ,
  output logic [WIDTH-1:0] iter_out
`endif
);

  mod_inverse_state_t state;

  logic [WIDTH-1:0]  a_reg, m_reg;
  logic [WIDTH-1:0]  r0, r1;
  logic signed [WIDTH:0] t0, t1;
  logic [WIDTH-1:0]  res;
  logic              err;
  logic              div_wait;
  logic              last_busy;
`ifdef MOD_INVERSE_ITER_EN
  logic [WIDTH-1:0]  iter_cnt;
`endif

  logic              div_start;
  logic [WIDTH-1:0]  div_dividend, div_divisor;
  logic [WIDTH-1:0]  div_quo, div_rem;
  logic              div_done;
  logic signed [WIDTH:0] qt;
  logic [WIDTH-1:0]  fixed;

  divmod_seq #(.WIDTH(WIDTH)) u_div (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .start_in     (div_start),
    .dividend_in  (div_dividend),
    .divisor_in   (div_divisor),
    .quotient_out (div_quo),
    .remainder_out(div_rem),
    .done_out     (div_done)
  );

  // Divider is started combinationally from the state so each Euclid step
  // costs exactly the divider latency plus the DIVIDE and UPDATE cycles.
  // NOTE: every always_comb output gets a default first so no path leaves
  // a signal unassigned, which would infer a latch.
  always_comb begin
    div_start    = 1'b0;
    div_dividend = r0;
    div_divisor  = r1;
    if (state == CHECK) begin
      div_dividend = a_reg;
      div_divisor  = m_reg;
      div_start    = (m_reg >= WIDTH'(2));
    end else if (state == DIVIDE) begin
      div_start = !div_wait && (r1 != '0);
    end
  end

  // |t| never exceeds m, so q*t1 is exact when kept at WIDTH+1 bits.
  assign qt = $signed({1'b0, div_quo}) * t1;

  // Negative t0 maps into [0,m) by adding m; modulo-2^WIDTH wrap is exact.
  always_comb begin
    fixed = t0[WIDTH-1:0];
    if (t0[WIDTH]) fixed = t0[WIDTH-1:0] + m_reg;
  end

  assign valid_out = last_busy && !busy_out;

  // NOTE: only control state and outputs are reset; datapath registers are
  // always written before they are read, so clearing them buys nothing.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= IDLE;
      busy_out  <= 1'b0;
      last_busy <= 1'b0;
      value_out <= '0;
      error_out <= 1'b0;
      div_wait  <= 1'b0;
`ifdef MOD_INVERSE_ITER_EN
      iter_out  <= '0;
      iter_cnt  <= '0;
`endif
    end else begin
      last_busy <= busy_out;
      case (state)
        IDLE: begin
          if (ready_in) begin
            a_reg    <= value_in;
            m_reg    <= modulus_in;
            busy_out <= 1'b1;
            state    <= CHECK;
`ifdef MOD_INVERSE_ITER_EN
            iter_cnt <= '0;
`endif
          end
        end
        CHECK: begin
          if (m_reg < WIDTH'(2)) begin
            res   <= '0;
            err   <= 1'b1;
            state <= DONE;
          end else begin
            r0    <= m_reg;
            t0    <= '0;
            t1    <= (WIDTH+1)'(1);
            state <= REDUCE;
          end
        end
        REDUCE: begin
          if (div_done) begin
            r1    <= div_rem;
            state <= DIVIDE;
          end
        end
        DIVIDE: begin
          if (!div_wait) begin
            if (r1 == '0) state <= FIXUP;
            else          div_wait <= 1'b1;
          end else if (div_done) begin
            div_wait <= 1'b0;
            state    <= UPDATE;
          end
        end
        UPDATE: begin
          r0    <= r1;
          r1    <= div_rem;
          t0    <= t1;
          t1    <= t0 - qt;
          state <= DIVIDE;
`ifdef MOD_INVERSE_ITER_EN
          iter_cnt <= iter_cnt + WIDTH'(1);
`endif
        end
        FIXUP: begin
          if (r0 != WIDTH'(1)) begin
            res <= '0;
            err <= 1'b1;
          end else begin
            res <= fixed;
            err <= 1'b0;
          end
          state <= DONE;
        end
        DONE: begin
          value_out <= res;
          error_out <= err;
          busy_out  <= 1'b0;
          state     <= IDLE;
`ifdef MOD_INVERSE_ITER_EN
          iter_out  <= iter_cnt;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_inverse.sv
// -----------------------------------------------------------------------------
// tb_mod_inverse
// Directed self-checking bench for mod_inverse (WIDTH=16). Expected values are
// hand-computed inverses; outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_mod_inverse;

  localparam int WIDTH = 16;
  localparam int BOUND = 30 * WIDTH + 60;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic             ready_in;
  logic [WIDTH-1:0] value_in;
  logic [WIDTH-1:0] modulus_in;
  logic [WIDTH-1:0] value_out;
  logic             error_out;
  logic             busy_out;
  logic             valid_out;
`ifdef MOD_INVERSE_ITER_EN
  logic [WIDTH-1:0] iter_out;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk_in = ~clk_in;

  mod_inverse #(.WIDTH(WIDTH)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .ready_in  (ready_in),
    .value_in  (value_in),
    .modulus_in(modulus_in),
    .value_out (value_out),
    .error_out (error_out),
    .busy_out  (busy_out),
    .valid_out (valid_out)
`ifdef MOD_INVERSE_ITER_EN
    ,
    .iter_out  (iter_out)
`endif
  );

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic start_job(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] m);
    value_in   = a;
    modulus_in = m;
    ready_in   = 1'b1;
    step();
    ready_in   = 1'b0;
  endtask

  // Steps until valid_out is seen or the cycle budget runs out.
  task automatic wait_valid(output int cycles, output bit timed_out);
    cycles    = 0;
    timed_out = 1'b0;
    while (!valid_out) begin
      if (cycles >= BOUND) begin
        timed_out = 1'b1;
        break;
      end
      step();
      cycles++;
    end
  endtask

  task automatic test_vector(input string name, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] exp_val,
                             input logic exp_err);
    int cyc;
    bit to;
    start_job(a, m);
    wait_valid(cyc, to);
    n_cmp++;
    if (to) begin
      n_mis++;
      $display("FAIL %s_timeout: no valid_out within %0d cycles", name, BOUND);
    end else begin
      n_cmp++;
      if (value_out !== exp_val) begin
        n_mis++;
        $display("FAIL %s_value: got %0d want %0d", name, value_out, exp_val);
      end
      n_cmp++;
      if (error_out !== exp_err) begin
        n_mis++;
        $display("FAIL %s_error: got %b want %b", name, error_out, exp_err);
      end
    end
    step();
  endtask

  task automatic test_reset();
    rst_in     = 1'b1;
    ready_in   = 1'b1;
    value_in   = 16'd3;
    modulus_in = 16'd7;
    repeat (3) step();
    n_cmp++;
    if (busy_out !== 1'b0) begin n_mis++; $display("FAIL reset_busy: got %b want 0", busy_out); end
    n_cmp++;
    if (valid_out !== 1'b0) begin n_mis++; $display("FAIL reset_valid: got %b want 0", valid_out); end
    n_cmp++;
    if (value_out !== '0) begin n_mis++; $display("FAIL reset_value: got %0d want 0", value_out); end
    n_cmp++;
    if (error_out !== 1'b0) begin n_mis++; $display("FAIL reset_error: got %b want 0", error_out); end
    ready_in = 1'b0;
    rst_in   = 1'b0;
    step();
    n_cmp++;
    if (busy_out !== 1'b0) begin n_mis++; $display("FAIL post_reset_busy: got %b want 0", busy_out); end
  endtask

  task automatic test_basic();
    int cyc;
    bit to;
    start_job(16'd3, 16'd7);
    n_cmp++;
    if (busy_out !== 1'b1) begin n_mis++; $display("FAIL basic_busy: got %b want 1", busy_out); end
    wait_valid(cyc, to);
    n_cmp++;
    if (to) begin
      n_mis++;
      $display("FAIL basic_timeout: no valid_out within %0d cycles", BOUND);
    end else begin
      n_cmp++;
      if (value_out !== 16'd5) begin n_mis++; $display("FAIL basic_value: got %0d want 5", value_out); end
      n_cmp++;
      if (error_out !== 1'b0) begin n_mis++; $display("FAIL basic_error: got %b want 0", error_out); end
`ifdef MOD_INVERSE_ITER_EN
      n_cmp++;
      if (iter_out !== 16'd2) begin n_mis++; $display("FAIL basic_iter: got %0d want 2", iter_out); end
`endif
      step();
      n_cmp++;
      if (valid_out !== 1'b0) begin n_mis++; $display("FAIL basic_valid_width: got %b want 0", valid_out); end
      n_cmp++;
      if (busy_out !== 1'b0) begin n_mis++; $display("FAIL basic_idle_busy: got %b want 0", busy_out); end
    end
  endtask

  task automatic test_arith();
    test_vector("rsa_d",     16'd17,    16'd3120,  16'd2753,  1'b0);
    test_vector("a_gt_m",    16'd10,    16'd7,     16'd5,     1'b0);
    test_vector("gcd3",      16'd6,     16'd9,     16'd0,     1'b1);
    test_vector("m_one",     16'd5,     16'd1,     16'd0,     1'b1);
    test_vector("a_zero",    16'd0,     16'd7,     16'd0,     1'b1);
    test_vector("a_mult_m",  16'd14,    16'd7,     16'd0,     1'b1);
    test_vector("a_one",     16'd1,     16'd7,     16'd1,     1'b0);
    test_vector("max_m",     16'd65534, 16'd65535, 16'd65534, 1'b0);
  endtask

  task automatic test_large();
    int cyc;
    bit to;
    start_job(16'd2, 16'd65521);
    wait_valid(cyc, to);
    n_cmp++;
    if (to || (cyc + 1) > BOUND) begin
      n_mis++;
      $display("FAIL large_latency: got %0d cycles want <= %0d", cyc + 1, BOUND);
    end
    n_cmp++;
    if (value_out !== 16'd32761) begin n_mis++; $display("FAIL large_value: got %0d want 32761", value_out); end
    n_cmp++;
    if (error_out !== 1'b0) begin n_mis++; $display("FAIL large_error: got %b want 0", error_out); end
    step();
  endtask

  // ready_in stays high and the operands change mid-job: one result only,
  // computed from the operands present at the accepting edge.
  task automatic test_hold();
    int cyc;
    bit to;
    int pulses;
    logic [WIDTH-1:0] got;
    value_in   = 16'd3;
    modulus_in = 16'd7;
    ready_in   = 1'b1;
    step();
    step();
    step();
    value_in   = 16'd6;
    modulus_in = 16'd9;
    wait_valid(cyc, to);
    got      = value_out;
    ready_in = 1'b0;
    pulses   = to ? 0 : 1;
    repeat (40) begin
      step();
      if (valid_out) pulses++;
    end
    n_cmp++;
    if (pulses != 1) begin n_mis++; $display("FAIL hold_pulses: got %0d want 1", pulses); end
    n_cmp++;
    if (got !== 16'd5) begin n_mis++; $display("FAIL hold_value: got %0d want 5", got); end
    n_cmp++;
    if (busy_out !== 1'b0) begin n_mis++; $display("FAIL hold_busy: got %b want 0", busy_out); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    start_job(16'd17, 16'd3120);
    repeat (WIDTH + 6) step();
    n_cmp++;
    if (busy_out !== 1'b1) begin n_mis++; $display("FAIL rmid_running: got %b want 1", busy_out); end
    rst_in = 1'b1;
    step();
    n_cmp++;
    if (busy_out !== 1'b0) begin n_mis++; $display("FAIL rmid_busy: got %b want 0", busy_out); end
    n_cmp++;
    if (value_out !== '0) begin n_mis++; $display("FAIL rmid_value: got %0d want 0", value_out); end
    rst_in = 1'b0;
    pulses = valid_out ? 1 : 0;
    repeat (60) begin
      step();
      if (valid_out) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin n_mis++; $display("FAIL rmid_no_valid: got %0d pulses want 0", pulses); end
    test_vector("after_reset", 16'd3, 16'd7, 16'd5, 1'b0);
  endtask

  // A start presented in the valid_out cycle must be accepted.
  task automatic test_back_to_back();
    int cyc;
    bit to;
    start_job(16'd3, 16'd7);
    wait_valid(cyc, to);
    n_cmp++;
    if (to || value_out !== 16'd5) begin
      n_mis++;
      $display("FAIL b2b_first: got %0d want 5", value_out);
    end
    start_job(16'd4, 16'd7);
    n_cmp++;
    if (busy_out !== 1'b1) begin n_mis++; $display("FAIL b2b_accept: got %b want 1", busy_out); end
    wait_valid(cyc, to);
    n_cmp++;
    if (to || value_out !== 16'd2) begin
      n_mis++;
      $display("FAIL b2b_second: got %0d want 2", value_out);
    end
    step();
  endtask

  initial begin
    ready_in   = 1'b0;
    value_in   = '0;
    modulus_in = '0;
    rst_in     = 1'b1;
    test_reset();
    test_basic();
    test_arith();
    test_large();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
